plic_gateway: RTL and testbench

- Interrupt gateway array that sits directly upstream of the PLIC core (priority/threshold/claim logic).
- Converts raw asynchronous source lines into one-request-at-a-time pending bits, ip_o, which feed the PLIC_IP register and the priority arbiter.
- Each source has a per-source trigger mode (level or edge) and an edge counter that saturates at the CTRL.TNM limit.
- A source raises a new request only after the core has claimed and completed the previous one.

---
 rtl/plic_gateway_pkg.sv | 13 +
 rtl/plic_gateway_if.sv | 27 ++
 rtl/plic_gateway_cell.sv | 75 +++++++
 rtl/plic_gateway.sv | 44 ++++
 tb/tb_plic_gateway.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/plic_gateway_pkg.sv
// Shared types and constants for the PLIC interrupt gateway array.
// State encodings match the PLIC define set (IDLE=0, PEND=1, INFL=2).
package plic_gateway_pkg;
  localparam int GWP_WIDTH = 3;
  localparam logic TM_LEVL = 1'b0;
  localparam logic TM_EDGE = 1'b1;

  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_PEND = 2'd1,
    GW_INFL = 2'd2
  } gw_state_e;
endpackage

// File: rtl/plic_gateway_if.sv
// Control, source lines and claim/complete handshake between PLIC core and gateway.
// master = core/control side, slave = gateway array.
interface plic_gateway_if #(
  parameter int IRQ_NUM   = 32,
  parameter int CNT_WIDTH = 3,
  parameter int ID_WIDTH  = $clog2(IRQ_NUM)
);
  logic                 en_i;
  logic [CNT_WIDTH-1:0] tnm_i;
  logic [IRQ_NUM-1:0]   tm_i;
  logic [IRQ_NUM-1:0]   irq_i;
  logic                 claim_i;
  logic [ID_WIDTH-1:0]  claim_id_i;
  logic                 complete_i;
  logic [ID_WIDTH-1:0]  complete_id_i;
  logic [IRQ_NUM-1:0]   ip_o;
  logic [IRQ_NUM-1:0]   busy_o;

  modport master (
    output en_i, tnm_i, tm_i, irq_i, claim_i, claim_id_i, complete_i, complete_id_i,
    input  ip_o, busy_o
  );
  modport slave (
    input  en_i, tnm_i, tm_i, irq_i, claim_i, claim_id_i, complete_i, complete_id_i,
    output ip_o, busy_o
  );
endinterface

// File: rtl/plic_gateway_cell.sv
// One gateway source: 2-flop sync, edge detect, saturating edge counter, IDLE/PEND/INFL FSM.
// Latency 3 edges from first edge sampling irq high to ip; no backpressure, claim/complete strobes.
module plic_gw_cell
  import plic_gateway_pkg::*;
#(
  parameter int CNT_WIDTH = GWP_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_en,
  input  logic [CNT_WIDTH-1:0] i_tnm,
  input  logic                 i_tm,
  input  logic                 i_irq,
  input  logic                 i_claim,
  input  logic                 i_complete,
  output logic                 o_ip,
  output logic                 o_busy
);
  logic                 r_s1, r_s2, r_s3, r_tm;
  logic [CNT_WIDTH-1:0] r_cnt;
  gw_state_e            r_state, w_state_nxt;

  logic                 w_rise, w_inc, w_take, w_req;
  logic [CNT_WIDTH-1:0] w_lim, w_base, w_cnt_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
      r_tm <= TM_LEVL;
    end else begin
      r_s1 <= i_irq;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_tm <= i_tm;
    end
  end

  // An edge arriving in the same cycle it is consumed lets the source go
  // straight to PEND, so edge latency equals level latency.
  always_comb begin
    w_rise    = r_s2 & ~r_s3;
    w_lim     = (i_tnm == '0) ? CNT_WIDTH'(1) : i_tnm;
    w_base    = (r_cnt > w_lim) ? w_lim : r_cnt;
    w_inc     = (i_tm == TM_EDGE) & i_en & w_rise & (w_base < w_lim);
    w_req     = i_en & ((i_tm == TM_EDGE) ? ((w_base != '0) | w_inc) : r_s2);
    w_take    = (r_state == GW_IDLE) & w_req & (i_tm == TM_EDGE);
    w_cnt_nxt = w_base + CNT_WIDTH'(w_inc) - CNT_WIDTH'(w_take);
    if (i_tm != r_tm) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= GW_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      GW_IDLE: if (w_req)      w_state_nxt = GW_PEND;
      GW_PEND: if (i_claim)    w_state_nxt = GW_INFL;
      GW_INFL: if (i_complete) w_state_nxt = GW_IDLE;
      default:                 w_state_nxt = GW_IDLE;
    endcase
  end

  assign o_ip   = (r_state == GW_PEND);
  assign o_busy = (r_state == GW_INFL);
endmodule

// File: rtl/plic_gateway.sv
// Gateway array for sources 1..IRQ_NUM-1; source 0 is reserved and tied off.
// Claim/complete IDs decoded to one-hot strobes; no backpressure.
module plic_gateway
  import plic_gateway_pkg::*;
#(
  parameter int IRQ_NUM   = 32,
  parameter int CNT_WIDTH = GWP_WIDTH,
  parameter int ID_WIDTH  = $clog2(IRQ_NUM)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  plic_gateway_if.slave  bus
);
  logic [IRQ_NUM-1:0] w_ip, w_busy;
  logic [IRQ_NUM-1:1] w_claim_oh, w_complete_oh;
  logic               w_unused_src0;

  assign w_ip[0]       = 1'b0;
  assign w_busy[0]     = 1'b0;
  assign w_unused_src0 = bus.irq_i[0] ^ bus.tm_i[0];

  for (genvar k = 1; k < IRQ_NUM; k++) begin : g_src
    assign w_claim_oh[k]    = bus.claim_i    && (bus.claim_id_i    == ID_WIDTH'(k));
    assign w_complete_oh[k] = bus.complete_i && (bus.complete_id_i == ID_WIDTH'(k));

    plic_gw_cell #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cell (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_en       (bus.en_i),
      .i_tnm      (bus.tnm_i),
      .i_tm       (bus.tm_i[k]),
      .i_irq      (bus.irq_i[k]),
      .i_claim    (w_claim_oh[k]),
      .i_complete (w_complete_oh[k]),
      .o_ip       (w_ip[k]),
      .o_busy     (w_busy[k])
    );
  end

  assign bus.ip_o   = w_ip;
  assign bus.busy_o = w_busy;
endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway: level-mode vector table, then edge-mode/reset sequences.
module tb_plic_gateway;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  plic_gateway_if #(.IRQ_NUM(32), .CNT_WIDTH(3), .ID_WIDTH(5)) bus ();

  plic_gateway #(.IRQ_NUM(32), .CNT_WIDTH(3), .ID_WIDTH(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] irq;
    logic        en;
    logic        claim;
    logic [4:0]  cid;
    logic        comp;
    logic [4:0]  pid;
    logic [31:0] ip;
    logic [31:0] busy;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [31:0] irq, input logic en, input logic claim, input logic [4:0] cid,
                     input logic comp, input logic [4:0] pid, input logic [31:0] ip, input logic [31:0] busy);
    vec_t v;
    v.irq = irq; v.en = en; v.claim = claim; v.cid = cid;
    v.comp = comp; v.pid = pid; v.ip = ip; v.busy = busy;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] ip_exp, input logic [31:0] busy_exp);
    n_checks++;
    if (bus.ip_o !== ip_exp || bus.busy_o !== busy_exp) begin
      n_fail++;
      $display("FAIL %s: ip_o=%h busy_o=%h, expected ip_o=%h busy_o=%h",
               name, bus.ip_o, bus.busy_o, ip_exp, busy_exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int id);
    bus.irq_i[id] = 1'b1;
    cyc(1);
    bus.irq_i[id] = 1'b0;
    cyc(1);
  endtask

  task automatic do_claim(input int id);
    bus.claim_i = 1'b1; bus.claim_id_i = 5'(id);
    cyc(1);
    bus.claim_i = 1'b0; bus.claim_id_i = '0;
  endtask

  task automatic do_comp(input int id);
    bus.complete_i = 1'b1; bus.complete_id_i = 5'(id);
    cyc(1);
    bus.complete_i = 1'b0; bus.complete_id_i = '0;
  endtask

  // Source must be IDLE; expects exactly n more requests, then silence.
  task automatic rounds(input string name, input int id, input int n);
    logic [31:0] b;
    b = 32'h1 << id;
    for (int r = 0; r < n + 2; r++) begin
      cyc(1);
      chk($sformatf("%s_round%0d", name, r), (r < n) ? b : 32'h0, 32'h0);
      if (r < n) begin
        do_claim(id);
        do_comp(id);
      end
    end
  endtask

  initial begin
    bus.en_i = 1'b1; bus.tnm_i = 3'd3; bus.tm_i = '0; bus.irq_i = '0;
    bus.claim_i = 1'b0; bus.claim_id_i = '0; bus.complete_i = 1'b0; bus.complete_id_i = '0;

    // Level-mode table: inputs applied for one clock, outputs checked 1ns after the edge.
    add(32'h00, 1, 0, 0, 0, 0, 32'h00, 32'h00);
    add(32'h20, 1, 0, 0, 0, 0, 32'h00, 32'h00);
    add(32'h20, 1, 0, 0, 0, 0, 32'h00, 32'h00);
    add(32'h20, 1, 0, 0, 0, 0, 32'h20, 32'h00);
    add(32'h00, 1, 0, 0, 0, 0, 32'h20, 32'h00);
    add(32'h00, 1, 0, 0, 1, 5, 32'h20, 32'h00);
    add(32'h00, 1, 1, 0, 0, 0, 32'h20, 32'h00);
    add(32'h00, 1, 1, 9, 0, 0, 32'h20, 32'h00);
    add(32'h00, 1, 1, 5, 0, 0, 32'h00, 32'h20);
    add(32'h20, 1, 0, 0, 0, 0, 32'h00, 32'h20);
    add(32'h20, 1, 0, 0, 1, 5, 32'h00, 32'h00);
    add(32'h20, 1, 0, 0, 0, 0, 32'h20, 32'h00);
    add(32'hA0, 0, 1, 5, 0, 0, 32'h00, 32'h20);
    add(32'hA0, 0, 0, 0, 0, 0, 32'h00, 32'h20);
    add(32'hA0, 0, 0, 0, 0, 0, 32'h00, 32'h20);
    add(32'hA0, 0, 0, 0, 1, 5, 32'h00, 32'h00);
    add(32'hA0, 1, 0, 0, 0, 0, 32'hA0, 32'h00);
    add(32'hA0, 1, 1, 7, 0, 0, 32'h20, 32'h80);
    add(32'h00, 1, 1, 5, 0, 0, 32'h00, 32'hA0);
    add(32'h00, 1, 0, 0, 1, 7, 32'h00, 32'h20);
    add(32'h00, 1, 0, 0, 1, 5, 32'h00, 32'h00);
    add(32'h00, 1, 0, 0, 0, 0, 32'h00, 32'h00);
    add(32'h51, 1, 0, 0, 0, 0, 32'h00, 32'h00);
    add(32'h51, 1, 0, 0, 0, 0, 32'h00, 32'h00);
    add(32'h51, 1, 0, 0, 0, 0, 32'h50, 32'h00);
    add(32'h01, 1, 1, 6, 0, 0, 32'h10, 32'h40);
    add(32'h01, 1, 1, 4, 1, 6, 32'h00, 32'h10);
    add(32'h00, 1, 0, 0, 1, 4, 32'h00, 32'h00);
    add(32'h00, 1, 0, 0, 0, 0, 32'h00, 32'h00);

    cyc(3);
    chk("reset_held", 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    chk("reset_released", 32'h0, 32'h0);

    for (int i = 0; i < vt.size(); i++) begin
      bus.irq_i = vt[i].irq; bus.en_i = vt[i].en;
      bus.claim_i = vt[i].claim; bus.claim_id_i = vt[i].cid;
      bus.complete_i = vt[i].comp; bus.complete_id_i = vt[i].pid;
      cyc(1);
      chk($sformatf("vec%0d", i), vt[i].ip, vt[i].busy);
    end
    bus.irq_i = '0; bus.claim_i = 1'b0; bus.complete_i = 1'b0;
    bus.claim_id_i = '0; bus.complete_id_i = '0; bus.en_i = 1'b1;

    // Edge saturation at tnm=3: six edges while in flight leave three requests.
    bus.tm_i = 32'h8; bus.tnm_i = 3'd3;
    cyc(3);
    pulse(3);
    cyc(1);
    chk("edge_first_req", 32'h8, 32'h0);
    do_claim(3);
    chk("edge_claimed", 32'h0, 32'h8);
    repeat (6) pulse(3);
    cyc(2);
    chk("edge_infl_hold", 32'h0, 32'h8);
    do_comp(3);
    chk("edge_completed", 32'h0, 32'h0);
    rounds("sat3", 3, 3);

    // tnm=0 behaves as a limit of one.
    bus.tnm_i = 3'd0;
    pulse(3);
    cyc(1);
    chk("tnm0_first_req", 32'h8, 32'h0);
    do_claim(3);
    repeat (4) pulse(3);
    cyc(2);
    do_comp(3);
    rounds("tnm0", 3, 1);

    // Lowering tnm below the stored count clamps it.
    bus.tnm_i = 3'd3;
    pulse(3);
    cyc(1);
    do_claim(3);
    repeat (3) pulse(3);
    cyc(2);
    bus.tnm_i = 3'd1;
    cyc(1);
    do_comp(3);
    rounds("clamp", 3, 1);
    bus.tnm_i = 3'd3;

    // Source 2: edge counted in the same cycle as the IDLE->PEND decrement.
    bus.tm_i = 32'hC;
    cyc(2);
    pulse(2);
    cyc(1);
    chk("simul_first_req", 32'h4, 32'h0);
    do_claim(2);
    pulse(2);
    cyc(2);
    bus.irq_i[2] = 1'b1;
    cyc(1);
    bus.irq_i[2] = 1'b0;
    do_comp(2);
    cyc(1);
    chk("simul_pend", 32'h4, 32'h0);
    do_claim(2);
    do_comp(2);
    rounds("simul", 2, 1);

    // Async reset mid-INFL with two edges banked.
    pulse(3);
    cyc(1);
    do_claim(3);
    repeat (2) pulse(3);
    cyc(2);
    chk("pre_reset_infl", 32'h0, 32'h8);
    #2 rst = 1'b1;
    #1 chk("reset_async", 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk($sformatf("post_reset%0d", i), 32'h0, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
